// File: rtl/mem_dcache_arbiter_pkg.sv
// Shared types for the MEM-stage data-cache arbiter: FSM state and the
// per-slot request bundle presented to the single cache port.
package mem_dcache_arbiter_pkg;

    localparam int unsigned ARB_SLOTS = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_DRAIN
    } dcache_arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        is_store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dcache_slot_req_t;

    // Oldest pending slot wins; slot 1 only when slot 0 has nothing left to do.
    function automatic logic pick_slot(input logic [ARB_SLOTS-1:0] pending);
        return pending[0] ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/mem_dcache_arbiter.sv
// Serialises up to two MEM-stage memory operations onto the single dcache port,
// holds per-slot load data until the bundle retires, and drives the MEM stall.
module mem_dcache_arbiter
    import mem_dcache_arbiter_pkg::*;
#(
    parameter int unsigned ISSUE_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ISSUE_WIDTH-1:0]      slot_mem_valid,
    input  logic [ISSUE_WIDTH-1:0]      slot_is_store,
    input  logic [ISSUE_WIDTH-1:0]      slot_excp,
    input  logic [ISSUE_WIDTH-1:0][31:0] slot_addr,
    input  logic [ISSUE_WIDTH-1:0][31:0] slot_wdata,
    input  logic [ISSUE_WIDTH-1:0][3:0] slot_wstrb,
    input  logic                        flush,
    output logic                        dcache_req,
    output logic                        dcache_we,
    output logic [31:0]                 dcache_addr,
    output logic [3:0]                  dcache_wstrb,
    output logic [31:0]                 dcache_wdata,
    input  logic                        dcache_addr_ok,
    input  logic                        dcache_data_ok,
    input  logic [31:0]                 dcache_rdata,
    output logic [ISSUE_WIDTH-1:0][31:0] slot_rdata,
    output logic [ISSUE_WIDTH-1:0]      slot_done,
    output logic                        pause_mem
);

    dcache_arb_state_t state_q, state_d;

    logic                         sel_q, sel_d, sel;
    logic [ISSUE_WIDTH-1:0]       done_q, done_d;
    logic [ISSUE_WIDTH-1:0][31:0] rdata_q, rdata_d;

    logic [ISSUE_WIDTH-1:0]       need, pending, complete, done_c;
    logic                         pause_c, issue;
    dcache_slot_req_t [ISSUE_WIDTH-1:0] slot_req;
    dcache_slot_req_t             cur_req;

    // An older exception kills the younger access; flush kills both.
    always_comb begin
        need[0] = slot_mem_valid[0] & ~slot_excp[0] & ~flush;
        need[1] = slot_mem_valid[1] & ~slot_excp[1] & ~slot_excp[0] & ~flush;
        pending = need & ~done_q;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            slot_req[i].valid    = pending[i];
            slot_req[i].is_store = slot_is_store[i];
            slot_req[i].addr     = slot_addr[i];
            slot_req[i].wdata    = slot_wdata[i];
            slot_req[i].wstrb    = slot_wstrb[i];
        end
        sel     = pick_slot(pending);
        cur_req = slot_req[sel];
        issue   = (state_q == ARB_IDLE) && cur_req.valid;
    end

    always_comb begin
        complete = '0;
        if (state_q == ARB_WAIT && dcache_data_ok) begin
            complete[sel_q] = 1'b1;
        end
        done_c  = done_q | complete | ~need;
        pause_c = (|(need & ~done_c)) || (state_q == ARB_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response coinciding with the flush finishes the transaction outright,
    // so DRAIN is only needed while the response is still outstanding.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (issue && dcache_addr_ok) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (dcache_data_ok)  state_d = ARB_IDLE;
                else if (flush)      state_d = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                if (dcache_data_ok)  state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        dcache_req   = 1'b0;
        dcache_we    = 1'b0;
        dcache_addr  = '0;
        dcache_wstrb = '0;
        dcache_wdata = '0;
        slot_rdata   = '0;
        slot_done    = '0;
        pause_mem    = 1'b0;
        if (!rst) begin
            dcache_req   = issue;
            dcache_we    = issue & cur_req.is_store;
            dcache_addr  = issue ? cur_req.addr  : '0;
            dcache_wstrb = issue ? cur_req.wstrb : '0;
            dcache_wdata = issue ? cur_req.wdata : '0;
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                slot_rdata[i] = complete[i] ? dcache_rdata : rdata_q[i];
            end
            slot_done = done_c;
            pause_mem = pause_c;
        end
    end

    always_comb begin
        sel_d   = sel_q;
        rdata_d = rdata_q;
        if (issue && dcache_addr_ok) sel_d = sel;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            if (complete[i]) rdata_d[i] = dcache_rdata;
        end
        // Retirement (no stall) wins over setting the last done bit.
        if (flush || !pause_c) done_d = '0;
        else                   done_d = done_q | complete;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= 1'b0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            sel_q   <= sel_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_dcache_arbiter.sv
// Self-checking bench for mem_dcache_arbiter: request-order scoreboard plus
// per-scenario checks on stall, done and load data.
module tb_mem_dcache_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        slot_mem_valid, slot_is_store, slot_excp;
    logic [1:0][31:0]  slot_addr, slot_wdata;
    logic [1:0][3:0]   slot_wstrb;
    logic              flush;
    logic              dcache_req, dcache_we;
    logic [31:0]       dcache_addr, dcache_wdata;
    logic [3:0]        dcache_wstrb;
    logic              dcache_addr_ok, dcache_data_ok;
    logic [31:0]       dcache_rdata;
    logic [1:0][31:0]  slot_rdata;
    logic [1:0]        slot_done;
    logic              pause_mem;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          issue_cnt = 0;
    logic [31:0] exp_rd0;

    mem_dcache_arbiter #(.ISSUE_WIDTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .slot_mem_valid (slot_mem_valid),
        .slot_is_store  (slot_is_store),
        .slot_excp      (slot_excp),
        .slot_addr      (slot_addr),
        .slot_wdata     (slot_wdata),
        .slot_wstrb     (slot_wstrb),
        .flush          (flush),
        .dcache_req     (dcache_req),
        .dcache_we      (dcache_we),
        .dcache_addr    (dcache_addr),
        .dcache_wstrb   (dcache_wstrb),
        .dcache_wdata   (dcache_wdata),
        .dcache_addr_ok (dcache_addr_ok),
        .dcache_data_ok (dcache_data_ok),
        .dcache_rdata   (dcache_rdata),
        .slot_rdata     (slot_rdata),
        .slot_done      (slot_done),
        .pause_mem      (pause_mem)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted request must match the oldest expected one.
    always @(negedge clk) begin
        req_t e;
        if (!rst && dcache_req && dcache_addr_ok) begin
            issue_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL req_order: got request addr=%08h, required no request", dcache_addr);
            end else begin
                e = exp_q.pop_front();
                if (dcache_we !== e.we || dcache_addr !== e.addr ||
                    dcache_wstrb !== e.wstrb || dcache_wdata !== e.wdata) begin
                    n_fails++;
                    $display("FAIL req_fields: got we=%0b addr=%08h wstrb=%h wdata=%08h, required we=%0b addr=%08h wstrb=%h wdata=%08h",
                             dcache_we, dcache_addr, dcache_wstrb, dcache_wdata,
                             e.we, e.addr, e.wstrb, e.wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        slot_mem_valid = '0;
        slot_is_store  = '0;
        slot_excp      = '0;
        slot_addr      = '0;
        slot_wdata     = '0;
        slot_wstrb     = '0;
        flush          = 1'b0;
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b0;
        dcache_rdata   = '0;
    endtask

    task automatic set_slot(input int s, input logic st, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws, input bit expect_issue);
        slot_mem_valid[s] = 1'b1;
        slot_is_store[s]  = st;
        slot_addr[s]      = a;
        slot_wdata[s]     = wd;
        slot_wstrb[s]     = ws;
        if (expect_issue) exp_q.push_back('{st, a, ws, wd});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({dcache_req, dcache_we, dcache_addr, dcache_wstrb, dcache_wdata} !== '0) begin
            n_fails++;
            $display("FAIL reset_req: got req=%0b addr=%08h, required 0", dcache_req, dcache_addr);
        end
        n_checks++;
        if (slot_done !== 2'b00 || pause_mem !== 1'b0 || slot_rdata !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got done=%b pause=%0b rdata0=%08h, required 00/0/0",
                     slot_done, pause_mem, slot_rdata[0]);
        end
        tick();
        rst = 1'b0;
        exp_rd0 = '0;
    endtask

    task automatic test_single_load();
        tick();
        set_slot(0, 1'b0, 32'h1C00_0100, '0, '0, 1'b1);
        dcache_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dcache_req !== 1'b1 || pause_mem !== 1'b1) begin
            n_fails++;
            $display("FAIL single_issue: got req=%0b pause=%0b, required 1/1", dcache_req, pause_mem);
        end
        tick();
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (pause_mem !== 1'b0 || slot_done !== 2'b11 || slot_rdata[0] !== 32'hDEAD_BEEF) begin
            n_fails++;
            $display("FAIL single_bypass: got pause=%0b done=%b rdata0=%08h, required 0/11/deadbeef",
                     pause_mem, slot_done, slot_rdata[0]);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (slot_rdata[0] !== 32'hDEAD_BEEF || dcache_req !== 1'b0 || pause_mem !== 1'b0) begin
            n_fails++;
            $display("FAIL single_hold: got rdata0=%08h req=%0b pause=%0b, required deadbeef/0/0",
                     slot_rdata[0], dcache_req, pause_mem);
        end
        exp_rd0 = 32'hDEAD_BEEF;
    endtask

    task automatic test_dual_load();
        int pause_cycles = 0;
        tick();
        set_slot(0, 1'b0, 32'h0000_0100, '0, '0, 1'b1);
        set_slot(1, 1'b0, 32'h0000_0104, '0, '0, 1'b1);
        dcache_addr_ok = 1'b1;
        @(negedge clk);
        if (pause_mem === 1'b1) pause_cycles++;
        tick();
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'h1111_1111;
        @(negedge clk);
        if (pause_mem === 1'b1) pause_cycles++;
        n_checks++;
        if (slot_done !== 2'b01 || slot_rdata[0] !== 32'h1111_1111 || dcache_req !== 1'b0) begin
            n_fails++;
            $display("FAIL dual_first: got done=%b rdata0=%08h req=%0b, required 01/11111111/0",
                     slot_done, slot_rdata[0], dcache_req);
        end
        tick();
        dcache_data_ok = 1'b0;
        dcache_addr_ok = 1'b1;
        dcache_rdata   = '0;
        @(negedge clk);
        if (pause_mem === 1'b1) pause_cycles++;
        tick();
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'h2222_2222;
        @(negedge clk);
        if (pause_mem === 1'b1) pause_cycles++;
        n_checks++;
        if (slot_done !== 2'b11 || slot_rdata[1] !== 32'h2222_2222 || slot_rdata[0] !== 32'h1111_1111) begin
            n_fails++;
            $display("FAIL dual_data: got done=%b rdata0=%08h rdata1=%08h, required 11/11111111/22222222",
                     slot_done, slot_rdata[0], slot_rdata[1]);
        end
        n_checks++;
        if (pause_cycles !== 3) begin
            n_fails++;
            $display("FAIL dual_pause_len: got %0d cycles, required 3", pause_cycles);
        end
        tick();
        idle_inputs();
        exp_rd0 = 32'h1111_1111;
    endtask

    task automatic test_addr_ok_stall();
        int issued0 = issue_cnt;
        int bad = 0;
        tick();
        set_slot(0, 1'b0, 32'h0000_0200, '0, '0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            dcache_addr_ok = (c == 4);
            @(negedge clk);
            if (dcache_req !== 1'b1 || dcache_addr !== 32'h0000_0200 || pause_mem !== 1'b1) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fails++;
            $display("FAIL stall_hold: got %0d unstable cycles, required 0", bad);
        end
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'h2222_0000;
        @(negedge clk);
        n_checks++;
        if (pause_mem !== 1'b0 || slot_rdata[0] !== 32'h2222_0000) begin
            n_fails++;
            $display("FAIL stall_data: got pause=%0b rdata0=%08h, required 0/22220000", pause_mem, slot_rdata[0]);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (issue_cnt - issued0 !== 1) begin
            n_fails++;
            $display("FAIL stall_issue_count: got %0d, required 1", issue_cnt - issued0);
        end
        exp_rd0 = 32'h2222_0000;
    endtask

    task automatic test_older_excp();
        tick();
        set_slot(0, 1'b0, 32'h0000_0300, '0, '0, 1'b0);
        set_slot(1, 1'b0, 32'h0000_0304, '0, '0, 1'b0);
        slot_excp      = 2'b01;
        dcache_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dcache_req !== 1'b0 || pause_mem !== 1'b0 || slot_done !== 2'b11) begin
            n_fails++;
            $display("FAIL excp_kill: got req=%0b pause=%0b done=%b, required 0/0/11",
                     dcache_req, pause_mem, slot_done);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush_drain();
        tick();
        set_slot(0, 1'b0, 32'h0000_0300, '0, '0, 1'b1);
        dcache_addr_ok = 1'b1;
        tick();
        dcache_addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dcache_req !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_wait_req: got req=%0b, required 0", dcache_req);
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (pause_mem !== 1'b1 || dcache_req !== 1'b0) begin
                n_fails++;
                $display("FAIL drain_pause: got pause=%0b req=%0b, required 1/0", pause_mem, dcache_req);
            end
            tick();
        end
        set_slot(0, 1'b0, 32'h0000_0400, '0, '0, 1'b1);
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'hBAD0_BAD0;
        @(negedge clk);
        n_checks++;
        if (pause_mem !== 1'b1 || dcache_req !== 1'b0 || slot_done[0] !== 1'b0) begin
            n_fails++;
            $display("FAIL drain_end: got pause=%0b req=%0b done0=%0b, required 1/0/0",
                     pause_mem, dcache_req, slot_done[0]);
        end
        tick();
        dcache_data_ok = 1'b0;
        dcache_rdata   = '0;
        dcache_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dcache_req !== 1'b1 || slot_rdata[0] !== exp_rd0) begin
            n_fails++;
            $display("FAIL drain_discard: got req=%0b rdata0=%08h, required 1/%08h", dcache_req, slot_rdata[0], exp_rd0);
        end
        tick();
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'h4444_4444;
        @(negedge clk);
        n_checks++;
        if (pause_mem !== 1'b0 || slot_rdata[0] !== 32'h4444_4444) begin
            n_fails++;
            $display("FAIL drain_next: got pause=%0b rdata0=%08h, required 0/44444444", pause_mem, slot_rdata[0]);
        end
        tick();
        idle_inputs();
        exp_rd0 = 32'h4444_4444;
    endtask

    task automatic test_store_load();
        tick();
        set_slot(0, 1'b1, 32'h0000_0500, 32'h0000_BEEF, 4'h3, 1'b1);
        set_slot(1, 1'b0, 32'h0000_0504, '0, '0, 1'b1);
        dcache_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dcache_we !== 1'b1) begin
            n_fails++;
            $display("FAIL st_we: got we=%0b, required 1", dcache_we);
        end
        tick();
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = '0;
        tick();
        dcache_data_ok = 1'b0;
        dcache_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dcache_we !== 1'b0 || dcache_req !== 1'b1) begin
            n_fails++;
            $display("FAIL ld_we: got we=%0b req=%0b, required 0/1", dcache_we, dcache_req);
        end
        tick();
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++;
        if (pause_mem !== 1'b0 || slot_rdata[1] !== 32'hCAFE_F00D || slot_rdata[0] !== 32'h0) begin
            n_fails++;
            $display("FAIL st_ld_data: got pause=%0b rdata0=%08h rdata1=%08h, required 0/00000000/cafef00d",
                     pause_mem, slot_rdata[0], slot_rdata[1]);
        end
        tick();
        idle_inputs();
        exp_rd0 = '0;
    endtask

    task automatic test_back_to_back();
        tick();
        set_slot(1, 1'b0, 32'h0000_0700, '0, '0, 1'b1);
        dcache_addr_ok = 1'b1;
        tick();
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'h7777_7777;
        tick();
        idle_inputs();
        set_slot(0, 1'b0, 32'h0000_0704, '0, '0, 1'b1);
        dcache_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dcache_req !== 1'b1) begin
            n_fails++;
            $display("FAIL b2b_no_gap: got req=%0b, required 1", dcache_req);
        end
        tick();
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'h8888_8888;
        tick();
        idle_inputs();
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'h9999_9999;
        @(negedge clk);
        n_checks++;
        if (pause_mem !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_data_ok_pause: got pause=%0b, required 0", pause_mem);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (slot_rdata[0] !== 32'h8888_8888 || slot_rdata[1] !== 32'h7777_7777) begin
            n_fails++;
            $display("FAIL idle_data_ok_ignored: got rdata0=%08h rdata1=%08h, required 88888888/77777777",
                     slot_rdata[0], slot_rdata[1]);
        end
    endtask

    task automatic test_midreset();
        tick();
        set_slot(0, 1'b0, 32'h0000_0800, '0, '0, 1'b1);
        dcache_addr_ok = 1'b1;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dcache_data_ok = 1'b1;
        dcache_rdata   = 32'h6666_6666;
        @(negedge clk);
        n_checks++;
        if (pause_mem !== 1'b0 || slot_rdata[0] !== 32'h0 || slot_done !== 2'b11) begin
            n_fails++;
            $display("FAIL midreset_ignore: got pause=%0b rdata0=%08h done=%b, required 0/00000000/11",
                     pause_mem, slot_rdata[0], slot_done);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (slot_rdata[0] !== 32'h0) begin
            n_fails++;
            $display("FAIL midreset_reg: got rdata0=%08h, required 00000000", slot_rdata[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_dual_load();
        test_addr_ok_stall();
        test_older_excp();
        test_flush_drain();
        test_store_load();
        test_back_to_back();
        test_midreset();
        tick();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d outstanding requests, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
